// File: rtl/uart_program_loader.sv
// -----------------------------------------------------------------------------
// uart_program_loader
//
// Receives a framed program image over the uart_rx byte handshake and writes
// it word by word into program RAM. The CPU is held in reset while a load is
// in progress.
//
// Frame layout:
//    SYNC_BYTE, LEN_LO, LEN_HI (word count N), 4*N data bytes (little-endian
//    words), CSUM (8-bit sum of all data bytes, mod 256).
//
// Ports:
//    clk         system clock
//    reset       asynchronous, active-high reset
//    rx_data     byte from uart_rx
//    rx_ready    uart_rx byte valid, held until acknowledged
//    rx_ack      one-cycle pulse: byte consumed
//    ram_we      one-cycle RAM write strobe
//    ram_addr    RAM word address (holds its last value between writes)
//    ram_din     RAM write data (meaningful only while ram_we=1)
//    cpu_hold    1 = hold the CPU in reset
//    load_done   level: last frame loaded with a good checksum
//    load_error  level: last frame failed (length, checksum or timeout)
//    busy        1 = frame in progress
// -----------------------------------------------------------------------------
module uart_program_loader #(
   parameter int unsigned ADDR_WIDTH     = 10,
   parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
   parameter int unsigned TIMEOUT_CYCLES = 2700000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [7:0]            rx_data,
   input  logic                  rx_ready,
   output logic                  rx_ack,
   output logic                  ram_we,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [31:0]           ram_din,
   output logic                  cpu_hold,
   output logic                  load_done,
   output logic                  load_error,
   output logic                  busy
);

   localparam int unsigned    TO_W      = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [16:0]    MAX_WORDS = 17'(2 ** ADDR_WIDTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN_LO,
      S_LEN_HI,
      S_DATA,
      S_CSUM,
      S_DONE,
      S_ERROR
   } state_t;

   state_t                state_reg, state_next;
   logic                  no_sample_reg;
   logic [15:0]           len_reg;
   logic [7:0]            csum_reg;
   logic [ADDR_WIDTH-1:0] word_idx_reg;
   logic [1:0]            byte_cnt_reg;
   logic [31:0]           asm_reg;
   logic                  we_reg;
   logic [ADDR_WIDTH-1:0] addr_reg;
   logic [TO_W-1:0]       timeout_reg;
   logic                  hold_reg;

   logic                  accept;
   logic                  in_frame;
   logic                  at_rest;
   logic                  frame_start;
   logic                  last_word;
   logic                  timeout_hit;
   logic [15:0]           len_rx;

   // A byte is taken whenever uart_rx offers one, except in the cycle right
   // after an acknowledge, where rx_ready may still show the old byte.
   assign accept      = rx_ready & ~no_sample_reg;
   assign in_frame    = (state_reg == S_LEN_LO) || (state_reg == S_LEN_HI) ||
                        (state_reg == S_DATA)   || (state_reg == S_CSUM);
   assign at_rest     = (state_reg == S_IDLE) || (state_reg == S_DONE) ||
                        (state_reg == S_ERROR);
   assign frame_start = at_rest & accept & (rx_data == SYNC_BYTE);
   assign len_rx      = {rx_data, len_reg[7:0]};
   assign last_word   = (16'(word_idx_reg) == (len_reg - 16'd1));
   // An arriving byte always beats an expiring timer.
   assign timeout_hit = in_frame & ~accept & (timeout_reg == TO_LAST);

   // ---------------------------------------------------------------- state
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= S_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // ----------------------------------------------------------- next state
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE, S_DONE, S_ERROR: begin
            if (frame_start) begin
               state_next = S_LEN_LO;
            end
         end
         S_LEN_LO: begin
            if (accept) begin
               state_next = S_LEN_HI;
            end
         end
         S_LEN_HI: begin
            if (accept) begin
               if ({1'b0, len_rx} > MAX_WORDS) begin
                  state_next = S_ERROR;
               end else if (len_rx == 16'd0) begin
                  state_next = S_CSUM;
               end else begin
                  state_next = S_DATA;
               end
            end
         end
         S_DATA: begin
            // Leave only once the final word's write strobe is out.
            if (we_reg && last_word) begin
               state_next = S_CSUM;
            end
         end
         S_CSUM: begin
            if (accept) begin
               state_next = (rx_data == csum_reg) ? S_DONE : S_ERROR;
            end
         end
         default: state_next = S_IDLE;
      endcase
      if (timeout_hit) begin
         state_next = S_ERROR;
      end
   end

   // ------------------------------------------------------------- datapath
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         no_sample_reg <= 1'b0;
         len_reg       <= '0;
         csum_reg      <= '0;
         word_idx_reg  <= '0;
         byte_cnt_reg  <= '0;
         asm_reg       <= '0;
         we_reg        <= 1'b0;
         addr_reg      <= '0;
         timeout_reg   <= '0;
         hold_reg      <= 1'b0;
      end else begin
         no_sample_reg <= accept;
         we_reg        <= 1'b0;

         if (in_frame && !accept) begin
            timeout_reg <= timeout_reg + TO_W'(1);
         end else begin
            timeout_reg <= '0;
         end

         // cpu_hold falls one cycle after the frame is declared good.
         if (frame_start) begin
            csum_reg     <= '0;
            word_idx_reg <= '0;
            byte_cnt_reg <= '0;
            hold_reg     <= 1'b1;
         end else if (state_reg == S_DONE) begin
            hold_reg <= 1'b0;
         end

         if (accept) begin
            case (state_reg)
               S_LEN_LO: len_reg[7:0]  <= rx_data;
               S_LEN_HI: len_reg[15:8] <= rx_data;
               S_DATA: begin
                  asm_reg      <= {rx_data, asm_reg[31:8]};
                  csum_reg     <= csum_reg + rx_data;
                  byte_cnt_reg <= byte_cnt_reg + 2'd1;
                  if (byte_cnt_reg == 2'd3) begin
                     we_reg   <= 1'b1;
                     addr_reg <= word_idx_reg;
                  end
               end
               default: ;
            endcase
         end

         // The index stops at N-1 so it never wraps, even for N = 2**ADDR_WIDTH.
         if (we_reg && !last_word) begin
            word_idx_reg <= word_idx_reg + ADDR_WIDTH'(1);
         end
      end
   end

   // -------------------------------------------------------------- outputs
   always_comb begin
      rx_ack     = accept;
      ram_we     = we_reg;
      ram_addr   = addr_reg;
      ram_din    = asm_reg;
      cpu_hold   = hold_reg;
      load_done  = (state_reg == S_DONE);
      load_error = (state_reg == S_ERROR);
      busy       = in_frame;
   end

endmodule

// File: tb/tb_uart_program_loader.sv
// -----------------------------------------------------------------------------
// tb_uart_program_loader
//
// Directed, table-driven bench for uart_program_loader with a short timeout.
// Whole frames come from a vector table; reset, timeout, back-to-back rx_ready
// and the maximum-length frame are hand-written sequences.
// -----------------------------------------------------------------------------
module tb_uart_program_loader;

   localparam int          AW   = 10;
   localparam logic [7:0]  SYNC = 8'hA5;
   localparam int          TOC  = 100;

   logic          clk;
   logic          reset;
   logic [7:0]    rx_data;
   logic          rx_ready;
   logic          rx_ack;
   logic          ram_we;
   logic [AW-1:0] ram_addr;
   logic [31:0]   ram_din;
   logic          cpu_hold;
   logic          load_done;
   logic          load_error;
   logic          busy;

   int n_checks = 0;
   int n_fail   = 0;

   logic [AW-1:0] wr_addr[$];
   logic [31:0]   wr_data[$];

   uart_program_loader #(
      .ADDR_WIDTH     (AW),
      .SYNC_BYTE      (SYNC),
      .TIMEOUT_CYCLES (TOC)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .rx_data    (rx_data),
      .rx_ready   (rx_ready),
      .rx_ack     (rx_ack),
      .ram_we     (ram_we),
      .ram_addr   (ram_addr),
      .ram_din    (ram_din),
      .cpu_hold   (cpu_hold),
      .load_done  (load_done),
      .load_error (load_error),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Log every RAM write strobe.
   always @(negedge clk) begin
      if (ram_we === 1'b1) begin
         wr_addr.push_back(ram_addr);
         wr_data.push_back(ram_din);
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [127:0]  bytes;   // last byte in the low 8 bits
      int            nbytes;
      logic          exp_done;
      logic          exp_err;
      logic          exp_hold;
      int            exp_nwr;
      logic [AW-1:0] a0;
      logic [31:0]   d0;
      logic [AW-1:0] a1;
      logic [31:0]   d1;
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      @(negedge clk);
      rx_data  = b;
      rx_ready = 1'b1;
      #1;
      while (rx_ack !== 1'b1 && n < 20) begin
         @(negedge clk);
         #1;
         n++;
      end
      check("rx_ack_seen", {31'b0, rx_ack}, 32'd1);
      @(posedge clk);
      #1;
      rx_ready = 1'b0;
   endtask

   task automatic clear_log();
      wr_addr.delete();
      wr_data.delete();
   endtask

   task automatic apply_vec(input int k);
      int   sh;
      logic [7:0] b;
      clear_log();
      for (int i = 0; i < vecs[k].nbytes; i++) begin
         sh = 8 * (vecs[k].nbytes - 1 - i);
         b  = vecs[k].bytes[sh +: 8];
         send_byte(b);
      end
      repeat (3) @(negedge clk);
      #1;
      check($sformatf("v%0d_load_done", k),  {31'b0, load_done},  {31'b0, vecs[k].exp_done});
      check($sformatf("v%0d_load_error", k), {31'b0, load_error}, {31'b0, vecs[k].exp_err});
      check($sformatf("v%0d_cpu_hold", k),   {31'b0, cpu_hold},   {31'b0, vecs[k].exp_hold});
      check($sformatf("v%0d_busy", k),       {31'b0, busy},       32'd0);
      check($sformatf("v%0d_nwrites", k),    wr_addr.size(),      vecs[k].exp_nwr);
      if (vecs[k].exp_nwr >= 1) begin
         check($sformatf("v%0d_addr0", k), 32'(wr_addr[0]), 32'(vecs[k].a0));
         check($sformatf("v%0d_data0", k), wr_data[0], vecs[k].d0);
      end
      if (vecs[k].exp_nwr >= 2) begin
         check($sformatf("v%0d_addr1", k), 32'(wr_addr[1]), 32'(vecs[k].a1));
         check($sformatf("v%0d_data1", k), wr_data[1], vecs[k].d1);
      end
      $display("vector %0d: %0d bytes, %0d writes, done=%0b error=%0b hold=%0b",
               k, vecs[k].nbytes, wr_addr.size(), load_done, load_error, cpu_hold);
   endtask

   function automatic logic [7:0] big_byte(input int i);
      return 8'((i * 7) + 3);
   endfunction

   initial begin
      logic [7:0]  sum;
      logic [31:0] last_w;

      // Data sum 11+22+33+44+AA+BB+CC+DD = 0x3B8 -> 0xB8.
      vecs[0] = '{128'({8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
                        8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hB8}), 12,
                  1'b1, 1'b0, 1'b0, 2, 10'd0, 32'h44332211, 10'd1, 32'hDDCCBBAA};
      vecs[1] = '{128'({8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
                        8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h0A}), 12,
                  1'b0, 1'b1, 1'b1, 2, 10'd0, 32'h44332211, 10'd1, 32'hDDCCBBAA};
      // Leading junk is discarded; 78+56+34+12 = 0x114 -> 0x14.
      vecs[2] = '{128'({8'h00, 8'hFF, 8'hA5, 8'h01, 8'h00, 8'h78, 8'h56,
                        8'h34, 8'h12, 8'h14}), 10,
                  1'b1, 1'b0, 1'b0, 1, 10'd0, 32'h12345678, 10'd0, 32'h0};
      // N = 1025 exceeds 1024 words.
      vecs[3] = '{128'({8'hA5, 8'h01, 8'h04}), 3,
                  1'b0, 1'b1, 1'b1, 0, 10'd0, 32'h0, 10'd0, 32'h0};
      // N = 0 with checksum 00.
      vecs[4] = '{128'({8'hA5, 8'h00, 8'h00, 8'h00}), 4,
                  1'b1, 1'b0, 1'b0, 0, 10'd0, 32'h0, 10'd0, 32'h0};
      // Sync value inside data is plain data; 4*A5 = 0x294 -> 0x94.
      vecs[5] = '{128'({8'hA5, 8'h01, 8'h00, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h94}), 8,
                  1'b1, 1'b0, 1'b0, 1, 10'd0, 32'hA5A5A5A5, 10'd0, 32'h0};

      reset    = 1'b1;
      rx_data  = 8'h00;
      rx_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_cpu_hold",   {31'b0, cpu_hold},   32'd0);
      check("rst_load_done",  {31'b0, load_done},  32'd0);
      check("rst_load_error", {31'b0, load_error}, 32'd0);
      check("rst_busy",       {31'b0, busy},       32'd0);
      check("rst_ram_we",     {31'b0, ram_we},     32'd0);
      check("rst_ram_addr",   32'(ram_addr),       32'd0);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      check("idle_busy", {31'b0, busy}, 32'd0);

      for (int k = 0; k < 6; k++) begin
         apply_vec(k);
      end

      // rx_ready left high past the acknowledge: the following cycle is ignored.
      @(negedge clk);
      rx_data  = 8'h00;
      rx_ready = 1'b1;
      #1;
      check("ack_first_cycle", {31'b0, rx_ack}, 32'd1);
      @(negedge clk);
      #1;
      check("ack_nosample_cycle", {31'b0, rx_ack}, 32'd0);
      rx_ready = 1'b0;
      $display("held rx_ready: second cycle ack=%0b", rx_ack);

      // Timeout: two data bytes, then silence.
      clear_log();
      send_byte(SYNC);
      send_byte(8'h01);
      send_byte(8'h00);
      send_byte(8'h11);
      send_byte(8'h22);
      repeat (99) @(posedge clk);
      #1;
      check("to_not_yet_error", {31'b0, load_error}, 32'd0);
      check("to_not_yet_busy",  {31'b0, busy},       32'd1);
      @(posedge clk);
      #1;
      check("to_error", {31'b0, load_error}, 32'd1);
      check("to_busy",  {31'b0, busy},       32'd0);
      check("to_hold",  {31'b0, cpu_hold},   32'd1);
      check("to_nwr",   wr_addr.size(),      32'd0);
      $display("timeout: error=%0b after 100 idle cycles", load_error);
      apply_vec(2);

      // Reset in the middle of DATA after one word has been written.
      clear_log();
      send_byte(SYNC);
      send_byte(8'h02);
      send_byte(8'h00);
      send_byte(8'h11);
      send_byte(8'h22);
      send_byte(8'h33);
      send_byte(8'h44);
      send_byte(8'h55);
      send_byte(8'h66);
      @(negedge clk);
      check("mid_nwr", wr_addr.size(), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      check("mid_rst_hold",  {31'b0, cpu_hold},   32'd0);
      check("mid_rst_busy",  {31'b0, busy},       32'd0);
      check("mid_rst_done",  {31'b0, load_done},  32'd0);
      check("mid_rst_error", {31'b0, load_error}, 32'd0);
      check("mid_rst_we",    {31'b0, ram_we},     32'd0);
      check("mid_rst_addr",  32'(ram_addr),       32'd0);
      check("mid_rst_din",   ram_din,             32'd0);
      @(negedge clk);
      reset = 1'b0;
      clear_log();
      send_byte(8'h77);
      send_byte(8'h88);
      repeat (3) @(negedge clk);
      check("post_rst_nwr",  wr_addr.size(), 32'd0);
      check("post_rst_busy", {31'b0, busy},  32'd0);
      $display("reset mid-frame: outputs cleared, leftover bytes discarded");
      apply_vec(0);

      // Maximum length frame: 1024 words.
      clear_log();
      sum = 8'h00;
      send_byte(SYNC);
      send_byte(8'h00);
      send_byte(8'h04);
      for (int i = 0; i < 4096; i++) begin
         send_byte(big_byte(i));
         sum = sum + big_byte(i);
      end
      send_byte(sum);
      repeat (3) @(negedge clk);
      last_w = {big_byte(4095), big_byte(4094), big_byte(4093), big_byte(4092)};
      check("max_nwr",        wr_addr.size(),    32'd1024);
      check("max_first_addr", 32'(wr_addr[0]),   32'd0);
      check("max_first_data", wr_data[0],
            {big_byte(3), big_byte(2), big_byte(1), big_byte(0)});
      check("max_last_addr",  32'(wr_addr[1023]), 32'd1023);
      check("max_last_data",  wr_data[1023],     last_w);
      check("max_done",       {31'b0, load_done}, 32'd1);
      check("max_hold",       {31'b0, cpu_hold},  32'd0);
      $display("max frame: %0d writes, done=%0b", wr_addr.size(), load_done);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
